// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Lets the core's load/store port (port 0) and the program loader/debug
// port (port 1) share the single-ported data memory. Only one transaction
// is in flight at a time. Requests that are misaligned or outside the memory
// are answered with an error and never reach the memory.
//
// Parameters
//   MEM_WORDS     number of 32-bit words behind the arbiter
//   READ_LATENCY  cycles from the MemRead edge to valid read_data (1..7)
//
// Ports
//   clock, reset            single rising-edge clock, async active-high reset
//   pX_req/we/addr/wdata    request from port X, held until its ack
//   pX_ack                  one-cycle completion pulse for port X
//   pX_err                  valid with pX_ack, 1 = access rejected
//   pX_rdata                last successful read result of port X
//   busy                    high whenever a transaction is being handled
//   MemRead/MemWrite        memory strobes, high only in the ACCESS cycle
//   endereco/write_data     memory address and write data (held between uses)
//   read_data               memory read data
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int MEM_WORDS    = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        busy,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] endereco,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);
  localparam logic [2:0]  LATENCY    = 3'(READ_LATENCY);

  state_t      state;
  state_t      next_state;

  logic        any_req;
  logic        sel_port;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;

  logic        grant;
  logic        last;
  logic        lat_we;
  logic        lat_err;
  logic [2:0]  wait_cnt;

  // Request selection. With both ports asking, the one that was not served
  // last wins; a lone requester always wins. The error check is done on the
  // request being granted so that a rejected access can be answered in the
  // very next cycle without touching the memory.
  always_comb begin
    any_req = p0_req | p1_req;
    if (p0_req && p1_req)
      sel_port = ~last;
    else
      sel_port = p1_req;
    sel_we    = sel_port ? p1_we    : p0_we;
    sel_addr  = sel_port ? p1_addr  : p0_addr;
    sel_wdata = sel_port ? p1_wdata : p0_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= WORD_LIMIT);
  end

  // State register. Reset forces IDLE at once, which also drops the strobes
  // and busy through the output decode; an in-flight transaction is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state decode. ACCESS and RESP always last one cycle; WAIT runs
  // until the latency counter reaches its final cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (any_req)
          next_state = sel_err ? RESP : ACCESS;
      end
      ACCESS: begin
        next_state = lat_we ? RESP : WAIT;
      end
      WAIT: begin
        if (wait_cnt == 3'd1)
          next_state = RESP;
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Transaction registers. The grant edge captures the granted request;
  // the memory address/data registers are only loaded for accesses that
  // will really be issued, so a rejected request leaves them untouched.
  // Read data is taken only on the last WAIT cycle, into the requester's
  // own result register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant      <= 1'b0;
      last       <= 1'b1;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      wait_cnt   <= 3'd0;
      endereco   <= 32'd0;
      write_data <= 32'd0;
      p0_rdata   <= 32'd0;
      p1_rdata   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= sel_port;
            last    <= sel_port;
            lat_we  <= sel_we;
            lat_err <= sel_err;
            if (!sel_err) begin
              endereco   <= sel_addr;
              write_data <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          if (!lat_we)
            wait_cnt <= LATENCY;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            if (grant)
              p1_rdata <= read_data;
            else
              p0_rdata <= read_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode. Strobes exist only in ACCESS and are mutually exclusive
  // by construction; ack/err go to the granted port only in RESP.
  always_comb begin
    busy     = (state != IDLE);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    p0_ack   = 1'b0;
    p1_ack   = 1'b0;
    p0_err   = 1'b0;
    p1_err   = 1'b0;
    if (state == ACCESS) begin
      MemWrite = lat_we;
      MemRead  = ~lat_we;
    end
    if (state == RESP) begin
      p0_ack = ~grant;
      p1_ack = grant;
      p0_err = ~grant & lat_err;
      p1_err = grant & lat_err;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives two arbiter instances: one with READ_LATENCY = 1 in front of a small
// behavioural memory, and one with READ_LATENCY = 3 whose read_data is driven
// directly so that the capture cycle can be observed. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset1 = 1'b1;
  logic        reset3 = 1'b1;

  // Instance with READ_LATENCY = 1
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic        p0_ack1, p0_err1, p1_ack1, p1_err1, busy1, mem_read1, mem_write1;
  logic [31:0] p0_rdata1, p1_rdata1, endereco1, write_data1;
  logic [31:0] read_data1;

  // Instance with READ_LATENCY = 3
  logic        p0_req3 = 1'b0, p0_we3 = 1'b0, p1_req3 = 1'b0, p1_we3 = 1'b0;
  logic [31:0] p0_addr3 = '0, p0_wdata3 = '0, p1_addr3 = '0, p1_wdata3 = '0;
  logic        p0_ack3, p0_err3, p1_ack3, p1_err3, busy3, mem_read3, mem_write3;
  logic [31:0] p0_rdata3, p1_rdata3, endereco3, write_data3;
  logic [31:0] read_data3 = '0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp0 = '0;
  logic [31:0] exp1 = '0;
  vec_t        vecs[11];

  logic [31:0] mem [256];
  logic [255:0] written;

  always #5 clock = ~clock;

  dmem_arbiter #(.MEM_WORDS(256), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset1),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack1), .p0_err(p0_err1), .p0_rdata(p0_rdata1),
    .p1_ack(p1_ack1), .p1_err(p1_err1), .p1_rdata(p1_rdata1),
    .busy(busy1), .MemRead(mem_read1), .MemWrite(mem_write1),
    .endereco(endereco1), .write_data(write_data1), .read_data(read_data1)
  );

  dmem_arbiter #(.MEM_WORDS(256), .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset3),
    .p0_req(p0_req3), .p0_we(p0_we3), .p0_addr(p0_addr3), .p0_wdata(p0_wdata3),
    .p1_req(p1_req3), .p1_we(p1_we3), .p1_addr(p1_addr3), .p1_wdata(p1_wdata3),
    .p0_ack(p0_ack3), .p0_err(p0_err3), .p0_rdata(p0_rdata3),
    .p1_ack(p1_ack3), .p1_err(p1_err3), .p1_rdata(p1_rdata3),
    .busy(busy3), .MemRead(mem_read3), .MemWrite(mem_write3),
    .endereco(endereco3), .write_data(write_data3), .read_data(read_data3)
  );

  // One-cycle-latency memory. Words never written read back as
  // 0xC0FFEE followed by the word index.
  always @(posedge clock) begin
    if (reset1) begin
      written <= '0;
    end else begin
      if (mem_write1) begin
        mem[endereco1[9:2]]     <= write_data1;
        written[endereco1[9:2]] <= 1'b1;
      end
      if (mem_read1)
        read_data1 <= written[endereco1[9:2]] ? mem[endereco1[9:2]]
                                               : {24'hC0FFEE, endereco1[9:2]};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Runs one uncontended transaction on the latency-1 instance. Called on a
  // falling edge while the arbiter is idle; returns on the falling edge of
  // the IDLE cycle that follows the ack.
  task automatic applyStimulus(input int idx, input vec_t v);
    int          ack_c = 0;
    int          strobe_c = 0;
    logic        strobe_we = 1'b0;
    logic        got_err = 1'b0;
    logic        other_ack = 1'b0;
    logic [31:0] seen_addr = '0;
    logic [31:0] seen_wdata = '0;
    if (v.port) begin
      p1_req = 1'b1; p1_we = v.we; p1_addr = v.addr; p1_wdata = v.wdata;
    end else begin
      p0_req = 1'b1; p0_we = v.we; p0_addr = v.addr; p0_wdata = v.wdata;
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if ((mem_read1 || mem_write1) && strobe_c == 0) begin
        strobe_c   = c;
        strobe_we  = mem_write1;
        seen_addr  = endereco1;
        seen_wdata = write_data1;
      end
      if (v.port ? p0_ack1 : p1_ack1)
        other_ack = 1'b1;
      if (v.port ? p1_ack1 : p0_ack1) begin
        ack_c   = c;
        got_err = v.port ? p1_err1 : p0_err1;
        break;
      end
    end
    if (v.port) p1_req = 1'b0; else p0_req = 1'b0;
    if (!v.we && !v.err) begin
      if (v.port) exp1 = v.rdata; else exp0 = v.rdata;
    end
    checkOutput($sformatf("vec%0d ack_cycle", idx), ack_c, v.lat);
    checkOutput($sformatf("vec%0d err", idx), {31'd0, got_err}, {31'd0, v.err});
    checkOutput($sformatf("vec%0d strobe_cycle", idx), strobe_c, v.err ? 0 : 1);
    checkOutput($sformatf("vec%0d other_ack", idx), {31'd0, other_ack}, 32'd0);
    if (!v.err) begin
      checkOutput($sformatf("vec%0d strobe_is_write", idx), {31'd0, strobe_we}, {31'd0, v.we});
      checkOutput($sformatf("vec%0d endereco", idx), seen_addr, v.addr);
      if (v.we)
        checkOutput($sformatf("vec%0d write_data", idx), seen_wdata, v.wdata);
    end
    checkOutput($sformatf("vec%0d p0_rdata", idx), p0_rdata1, exp0);
    checkOutput($sformatf("vec%0d p1_rdata", idx), p1_rdata1, exp1);
    @(negedge clock);
  endtask

  // Both ports raise a read on the same edge; ack cycles show the order.
  task automatic runTie(input string name, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int l0, input int l1);
    int c0 = 0;
    int c1 = 0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = a0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = a1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (p0_ack1 && c0 == 0) begin
        c0 = c;
        checkOutput({name, " p0_rdata"}, p0_rdata1, d0);
        checkOutput({name, " p0_err"}, {31'd0, p0_err1}, 32'd0);
        p0_req = 1'b0;
      end
      if (p1_ack1 && c1 == 0) begin
        c1 = c;
        checkOutput({name, " p1_rdata"}, p1_rdata1, d1);
        checkOutput({name, " p1_err"}, {31'd0, p1_err1}, 32'd0);
        p1_req = 1'b0;
      end
      if (c0 != 0 && c1 != 0)
        break;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    checkOutput({name, " p0_ack_cycle"}, c0, l0);
    checkOutput({name, " p1_ack_cycle"}, c1, l1);
    exp0 = d0;
    exp1 = d1;
    @(negedge clock);
  endtask

  initial begin
    int          acks0;
    int          first_c;
    int          second_c;
    int          p1_c;
    int          strobe_c;
    int          ack_c;
    int          stray;
    logic [31:0] rd;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0, 2};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  1'b0, 3};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'h0,          1'b1, 1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0400, 32'h0,         32'h0,          1'b1, 1};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_03FC, 32'h1234_5678, 32'h0,          1'b0, 2};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         32'h1234_5678,  1'b0, 3};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 32'h0,          1'b1, 1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  1'b0, 3};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,          1'b0, 2};
    vecs[9]  = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,          1'b1, 1};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_F00D,  1'b0, 3};

    @(negedge clock);
    @(negedge clock);
    reset1 = 1'b0;
    reset3 = 1'b0;
    $display("[TB] reset released");

    checkOutput("reset flags1",
                {25'd0, p0_ack1, p0_err1, p1_ack1, p1_err1, busy1, mem_read1, mem_write1}, 32'd0);
    checkOutput("reset endereco1", endereco1, 32'd0);
    checkOutput("reset write_data1", write_data1, 32'd0);
    checkOutput("reset p0_rdata1", p0_rdata1, 32'd0);
    checkOutput("reset p1_rdata1", p1_rdata1, 32'd0);
    checkOutput("reset flags3",
                {25'd0, p0_ack3, p0_err3, p1_ack3, p1_err3, busy3, mem_read3, mem_write3}, 32'd0);

    // First tie after reset: port 0 wins, port 1 follows at the next IDLE.
    runTie("tie1", 32'h040, 32'h044, 32'hC0FFEE10, 32'hC0FFEE11, 3, 7);

    for (int i = 0; i < 11; i++)
      applyStimulus(i, vecs[i]);

    // Port 0 was served last, so the repeated tie goes to port 1 first.
    runTie("tie2", 32'h3FC, 32'h020, 32'h1234_5678, 32'hCAFE_F00D, 7, 3);

    // Port 0 keeps req high through the IDLE after its write ack and gets a
    // second (read) transaction; port 1 arrives meanwhile and is served next.
    acks0 = 0; first_c = 0; second_c = 0; p1_c = 0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h080; p0_wdata = 32'hA5A5_A5A5;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (p0_ack1) begin
        acks0++;
        if (acks0 == 1) begin
          first_c = c;
          p0_we = 1'b0;
        end else begin
          second_c = c;
          checkOutput("b2b p0_rdata", p0_rdata1, 32'hA5A5_A5A5);
          p0_req = 1'b0;
        end
      end
      if (p1_ack1) begin
        p1_c = c;
        checkOutput("b2b p1_rdata", p1_rdata1, 32'hA5A5_A5A5);
        p1_req = 1'b0;
        break;
      end
      if (c == 4) begin
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h080;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    checkOutput("b2b first_ack", first_c, 2);
    checkOutput("b2b second_ack", second_c, 6);
    checkOutput("b2b p1_ack", p1_c, 10);
    @(negedge clock);

    // READ_LATENCY = 3: only the value present on the last WAIT cycle counts.
    strobe_c = 0; ack_c = 0; rd = '0;
    p0_req3 = 1'b1; p0_we3 = 1'b0; p0_addr3 = 32'h100; read_data3 = 32'hBAD0_0000;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (mem_read3 && strobe_c == 0) begin
        strobe_c = c;
        checkOutput("rl3 endereco", endereco3, 32'h100);
      end
      if (p0_ack3) begin
        ack_c = c;
        rd = p0_rdata3;
        checkOutput("rl3 err", {31'd0, p0_err3}, 32'd0);
        p0_req3 = 1'b0;
        break;
      end
      read_data3 = (c == 4) ? 32'h600D_DA7A : (32'hBAD0_0000 + 32'(c));
    end
    p0_req3 = 1'b0;
    checkOutput("rl3 strobe_cycle", strobe_c, 1);
    checkOutput("rl3 ack_cycle", ack_c, 5);
    checkOutput("rl3 p0_rdata", rd, 32'h600D_DA7A);
    @(negedge clock);

    // Reset during WAIT of a port 1 read drops the transaction.
    p1_req3 = 1'b1; p1_we3 = 1'b0; p1_addr3 = 32'h104; read_data3 = 32'h7777_7777;
    @(negedge clock);
    checkOutput("rst ACCESS MemRead", {31'd0, mem_read3}, 32'd1);
    @(negedge clock);
    checkOutput("rst WAIT busy", {31'd0, busy3}, 32'd1);
    #1 reset3 = 1'b1;
    #1;
    checkOutput("rst async flags",
                {27'd0, mem_read3, mem_write3, busy3, p0_ack3, p1_ack3}, 32'd0);
    checkOutput("rst p0_rdata3", p0_rdata3, 32'd0);
    checkOutput("rst write_data3", write_data3, 32'd0);
    p1_req3 = 1'b0;
    @(negedge clock);
    reset3 = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (p0_ack3 || p1_ack3 || busy3)
        stray++;
    end
    checkOutput("rst no ack/busy after reset", stray, 0);

    ack_c = 0; rd = '0;
    p1_req3 = 1'b1; p1_we3 = 1'b0; p1_addr3 = 32'h104; read_data3 = 32'h1111_2222;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (p1_ack3) begin
        ack_c = c;
        rd = p1_rdata3;
        checkOutput("reissue err", {31'd0, p1_err3}, 32'd0);
        break;
      end
    end
    p1_req3 = 1'b0;
    checkOutput("reissue ack_cycle", ack_c, 5);
    checkOutput("reissue p1_rdata", rd, 32'h1111_2222);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
